// File: rtl/exec_stage_if.sv
// Signal bundle between the execute stage and its neighbours (decode, hazard unit, memory stage).
// The master side drives decode/forwarding inputs; the slave side is the execute stage itself.
interface exec_stage_if;
    logic        stall;
    logic [31:0] instr_D;
    logic [31:0] PC_D;
    logic [31:0] regRD1_D;
    logic [31:0] regRD2_D;
    logic [31:0] extRes_D;
    logic [1:0]  fwdSel1_E;
    logic [1:0]  fwdSel2_E;
    logic [31:0] fwdData_M;
    logic [31:0] fwdData_W;
    logic [31:0] instr_E;
    logic [31:0] PC_E;
    logic [31:0] extRes_E;
    logic [31:0] F_regA1Data_E;
    logic [31:0] F_regA2Data_E;
    logic [31:0] aluRes_E;
    logic [2:0]  Tnew_E;
    logic        mdStart_E;
    logic        busy_E;

    modport master (
        output stall, instr_D, PC_D, regRD1_D, regRD2_D, extRes_D,
               fwdSel1_E, fwdSel2_E, fwdData_M, fwdData_W,
        input  instr_E, PC_E, extRes_E, F_regA1Data_E, F_regA2Data_E,
               aluRes_E, Tnew_E, mdStart_E, busy_E
    );

    modport slave (
        input  stall, instr_D, PC_D, regRD1_D, regRD2_D, extRes_D,
               fwdSel1_E, fwdSel2_E, fwdData_M, fwdData_W,
        output instr_E, PC_E, extRes_E, F_regA1Data_E, F_regA2Data_E,
               aluRes_E, Tnew_E, mdStart_E, busy_E
    );
endinterface

// File: rtl/exec_stage.sv
// MIPS execute stage: D->E pipeline register, operand forwarding, ALU, Tnew reporting,
// and a multi-cycle multiply/divide unit that owns the HI/LO registers.
module exec_stage #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    exec_stage_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW  = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_MFHI  = 6'h10, FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTHI  = 6'h11, FN_MTLO = 6'h13, FN_MULT  = 6'h18, FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A, FN_DIVU = 6'h1B;

    logic [31:0]      instr_q, pc_q, rd1_q, rd2_q, ext_q;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_s, b_s, alu_s, b_safe_s;
    logic [31:0]      quot_sgn_s, rem_sgn_s, quot_uns_s, rem_uns_s;
    logic [63:0]      prod_sgn_s, prod_uns_s;
    logic [2:0]       tnew_s;
    logic [5:0]       op_s, fn_s;
    logic             is_md_s, busy_s, md_start_s, div_ok_s;

    assign op_s       = instr_q[31:26];
    assign fn_s       = instr_q[5:0];
    assign is_md_s    = (op_s == OP_RTYPE) &&
                        ((fn_s == FN_MULT) || (fn_s == FN_MULTU) || (fn_s == FN_DIV) ||
                         (fn_s == FN_DIVU) || (fn_s == FN_MTHI)  || (fn_s == FN_MTLO));
    assign busy_s     = (cnt_q != {CNT_W{1'b0}});
    assign md_start_s = is_md_s && !busy_s;

    // D->E pipeline register; a stall loads a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= 32'd0; pc_q <= 32'd0; rd1_q <= 32'd0; rd2_q <= 32'd0; ext_q <= 32'd0;
        end else if (bus.stall) begin
            instr_q <= 32'd0; pc_q <= 32'd0; rd1_q <= 32'd0; rd2_q <= 32'd0; ext_q <= 32'd0;
        end else begin
            instr_q <= bus.instr_D; pc_q <= bus.PC_D; rd1_q <= bus.regRD1_D;
            rd2_q   <= bus.regRD2_D; ext_q <= bus.extRes_D;
        end
    end

    // Operand forwarding muxes; selector 3 falls back to the own register like 0
    always_comb begin
        case (bus.fwdSel1_E)
            2'd1:    a_s = bus.fwdData_M;
            2'd2:    a_s = bus.fwdData_W;
            default: a_s = rd1_q;
        endcase
        case (bus.fwdSel2_E)
            2'd1:    b_s = bus.fwdData_M;
            2'd2:    b_s = bus.fwdData_W;
            default: b_s = rd2_q;
        endcase
    end

    // ALU result and Tnew decode
    always_comb begin
        alu_s  = 32'd0;
        tnew_s = 3'd0;
        case (op_s)
            OP_RTYPE: begin
                case (fn_s)
                    FN_ADD:  begin alu_s = a_s + b_s; tnew_s = 3'd1; end
                    FN_SUB:  begin alu_s = a_s - b_s; tnew_s = 3'd1; end
                    FN_MFHI: begin alu_s = hi_q;      tnew_s = 3'd1; end
                    FN_MFLO: begin alu_s = lo_q;      tnew_s = 3'd1; end
                    default: begin alu_s = 32'd0;     tnew_s = 3'd0; end
                endcase
            end
            OP_ORI:  begin alu_s = a_s | ext_q;   tnew_s = 3'd1; end
            OP_LUI:  begin alu_s = ext_q;         tnew_s = 3'd1; end
            OP_LW:   begin alu_s = a_s + ext_q;   tnew_s = 3'd2; end
            OP_SW:   begin alu_s = a_s + ext_q;   tnew_s = 3'd0; end
            OP_JAL:  begin alu_s = pc_q + 32'd8;  tnew_s = 3'd0; end
            default: begin alu_s = 32'd0;         tnew_s = 3'd0; end
        endcase
    end

    // Arithmetic for the multiply/divide unit; a zero divisor is replaced so the divider stays defined
    assign div_ok_s   = (b_s != 32'd0);
    assign b_safe_s   = div_ok_s ? b_s : 32'd1;
    assign prod_sgn_s = {{32{a_s[31]}}, a_s} * {{32{b_s[31]}}, b_s};
    assign prod_uns_s = {32'd0, a_s} * {32'd0, b_s};
    assign quot_sgn_s = $signed(a_s) / $signed(b_safe_s);
    assign rem_sgn_s  = $signed(a_s) % $signed(b_safe_s);
    assign quot_uns_s = a_s / b_safe_s;
    assign rem_uns_s  = a_s % b_safe_s;

    // Multiply/divide next state: start, countdown, and HI/LO commit on the final count
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        cnt_d     = cnt_q;
        if (md_start_s) begin
            case (fn_s)
                FN_MULT:  begin pend_hi_d = prod_sgn_s[63:32]; pend_lo_d = prod_sgn_s[31:0];
                                pend_wr_d = 1'b1; cnt_d = CNT_W'(MULT_CYCLES); end
                FN_MULTU: begin pend_hi_d = prod_uns_s[63:32]; pend_lo_d = prod_uns_s[31:0];
                                pend_wr_d = 1'b1; cnt_d = CNT_W'(MULT_CYCLES); end
                FN_DIV:   begin pend_hi_d = rem_sgn_s; pend_lo_d = quot_sgn_s;
                                pend_wr_d = div_ok_s; cnt_d = CNT_W'(DIV_CYCLES); end
                FN_DIVU:  begin pend_hi_d = rem_uns_s; pend_lo_d = quot_uns_s;
                                pend_wr_d = div_ok_s; cnt_d = CNT_W'(DIV_CYCLES); end
                FN_MTHI:  hi_d = a_s;
                FN_MTLO:  lo_d = a_s;
                default:  cnt_d = cnt_q;
            endcase
        end else if (busy_s) begin
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q == CNT_W'(1)) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end else begin
                hi_d = hi_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Multiply/divide state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'd0; lo_q <= 32'd0; pend_hi_q <= 32'd0; pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0; cnt_q <= {CNT_W{1'b0}};
        end else begin
            hi_q <= hi_d; lo_q <= lo_d; pend_hi_q <= pend_hi_d; pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d; cnt_q <= cnt_d;
        end
    end

    assign bus.instr_E       = instr_q;
    assign bus.PC_E          = pc_q;
    assign bus.extRes_E      = ext_q;
    assign bus.F_regA1Data_E = a_s;
    assign bus.F_regA2Data_E = b_s;
    assign bus.aluRes_E      = alu_s;
    assign bus.Tnew_E        = tnew_s;
    assign bus.mdStart_E     = md_start_s;
    assign bus.busy_E        = busy_s;
endmodule
